// File: rtl/regfile_write_arbiter.sv
// Shares the register_file write port between the ALU and load writeback paths.
// Latency: a request accepted at edge N drives RW during cycle N+1 at the earliest.
// Backpressure: one-entry buffer per side; ready = buffer empty or draining now; both ready low during flush.
module regfile_write_arbiter #(
  parameter int              DW      = 32,
  parameter int              AW      = 4,
  parameter logic [AW-1:0]   PC_ADDR = AW'(4'hF)
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          flush,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          RW,
  output logic [AW-1:0] writeAddress,
  output logic [DW-1:0] I0,
  output logic          pc_wr,
  input  logic [AW-1:0] addressA,
  input  logic [AW-1:0] addressB,
  output logic          hazard_a,
  output logic          hazard_b
);

  // Holding buffers
  logic          abuf_v_q, abuf_v_d;
  logic [AW-1:0] abuf_addr_q, abuf_addr_d;
  logic [DW-1:0] abuf_data_q, abuf_data_d;
  logic          mbuf_v_q, mbuf_v_d;
  logic [AW-1:0] mbuf_addr_q, mbuf_addr_d;
  logic [DW-1:0] mbuf_data_q, mbuf_data_d;

  // Ordering state: old_q names the older buffer (0 = ALU, 1 = MEM) when both were
  // loaded on different edges; same_q marks both loaded on the same edge.
  logic          old_q, old_d;
  logic          same_q, same_d;
  logic          rr_q, rr_d;

  // Registered write port
  logic          rw_q, rw_d;
  logic          pc_wr_q, pc_wr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          grant_alu, grant_mem;
  logic          issue;
  logic          alu_acc, mem_acc;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  // Grant selection, driven purely by buffer contents
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (abuf_v_q && mbuf_v_q) begin
      if (!same_q) begin
        if (old_q) grant_mem = 1'b1;
        else       grant_alu = 1'b1;
      end else if (abuf_addr_q == mbuf_addr_q) begin
        // Same destination loaded together: ALU first so the load value lands last
        grant_alu = 1'b1;
      end else if (rr_q) begin
        grant_alu = 1'b1;
      end else begin
        grant_mem = 1'b1;
      end
    end else if (abuf_v_q) begin
      grant_alu = 1'b1;
    end else if (mbuf_v_q) begin
      grant_mem = 1'b1;
    end
  end

  // A flush discards buffered writes, so nothing issues on that edge
  assign issue    = (grant_alu | grant_mem) & ~flush;
  assign gnt_addr = grant_mem ? mbuf_addr_q : abuf_addr_q;
  assign gnt_data = grant_mem ? mbuf_data_q : abuf_data_q;

  assign alu_ready = ~flush & (~abuf_v_q | grant_alu);
  assign mem_ready = ~flush & (~mbuf_v_q | grant_mem);
  assign alu_acc   = alu_valid & alu_ready;
  assign mem_acc   = mem_valid & mem_ready;

  // Next-state for buffers, ordering state and the write port
  always_comb begin
    abuf_v_d    = abuf_v_q;
    abuf_addr_d = abuf_addr_q;
    abuf_data_d = abuf_data_q;
    mbuf_v_d    = mbuf_v_q;
    mbuf_addr_d = mbuf_addr_q;
    mbuf_data_d = mbuf_data_q;
    old_d       = old_q;
    same_d      = same_q;
    rr_d        = rr_q;

    if (flush) begin
      abuf_v_d = 1'b0;
    end else if (alu_acc) begin
      abuf_v_d    = 1'b1;
      abuf_addr_d = alu_addr;
      abuf_data_d = alu_data;
    end else if (grant_alu) begin
      abuf_v_d = 1'b0;
    end

    if (flush) begin
      mbuf_v_d = 1'b0;
    end else if (mem_acc) begin
      mbuf_v_d    = 1'b1;
      mbuf_addr_d = mem_addr;
      mbuf_data_d = mem_data;
    end else if (grant_mem) begin
      mbuf_v_d = 1'b0;
    end

    // Whichever side was not loaded this edge is the older one
    if (alu_acc && mem_acc) begin
      same_d = 1'b1;
    end else if (alu_acc) begin
      same_d = 1'b0;
      old_d  = 1'b1;
    end else if (mem_acc) begin
      same_d = 1'b0;
      old_d  = 1'b0;
    end

    if (issue) rr_d = grant_mem;

    rw_d    = issue;
    pc_wr_d = issue && (gnt_addr == PC_ADDR);
    waddr_d = issue ? gnt_addr : waddr_q;
    wdata_d = issue ? gnt_data : wdata_q;
  end

  // State registers with asynchronous clear
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      abuf_v_q    <= 1'b0;
      abuf_addr_q <= '0;
      abuf_data_q <= '0;
      mbuf_v_q    <= 1'b0;
      mbuf_addr_q <= '0;
      mbuf_data_q <= '0;
      old_q       <= 1'b0;
      same_q      <= 1'b0;
      rr_q        <= 1'b1;
      rw_q        <= 1'b0;
      pc_wr_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      abuf_v_q    <= abuf_v_d;
      abuf_addr_q <= abuf_addr_d;
      abuf_data_q <= abuf_data_d;
      mbuf_v_q    <= mbuf_v_d;
      mbuf_addr_q <= mbuf_addr_d;
      mbuf_data_q <= mbuf_data_d;
      old_q       <= old_d;
      same_q      <= same_d;
      rr_q        <= rr_d;
      rw_q        <= rw_d;
      pc_wr_q     <= pc_wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign RW           = rw_q;
  assign pc_wr        = pc_wr_q;
  assign writeAddress = waddr_q;
  assign I0           = wdata_q;

  // Read hazards cover both buffered and in-flight writes
  assign hazard_a = (abuf_v_q && (abuf_addr_q == addressA)) ||
                    (mbuf_v_q && (mbuf_addr_q == addressA)) ||
                    (rw_q     && (waddr_q     == addressA));
  assign hazard_b = (abuf_v_q && (abuf_addr_q == addressB)) ||
                    (mbuf_v_q && (mbuf_addr_q == addressB)) ||
                    (rw_q     && (waddr_q     == addressB));

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of register_file (RW, writeAddress, I0) between two writeback requesters: the ALU result path and the memory-load path.
- Each requester has a valid/ready handshake backed by a one-entry holding buffer.
- Arbitration is round-robin with age ordering, and the block issues at most one register write per cycle.
- Also produces read-hazard flags for the decode stage and a PC-write pulse for R15 writes.

Parameters:
- DW, 32, data width of the write data and of I0.
- AW, 4, register address width (R0..R15).
- PC_ADDR, 4'hF, address that raises pc_wr.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- CLR  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards buffered, not-yet-issued writes.
- alu_valid  in  1  ALU write request.
- alu_addr  in  AW  ALU destination register.
- alu_data  in  DW  ALU write data.
- alu_ready  out  1  ALU request accepted this cycle when alu_valid and alu_ready are both high.
- mem_valid  in  1  load write request.
- mem_addr  in  AW  load destination register.
- mem_data  in  DW  load write data.
- mem_ready  out  1  load request accepted when mem_valid and mem_ready are both high.
- RW  out  1  register_file write enable, registered.
- writeAddress  out  AW  register_file write address, registered.
- I0  out  DW  register_file write data, registered.
- pc_wr  out  1  registered; high in the same cycle as RW when writeAddress == PC_ADDR.
- addressA  in  AW  decode read address A.
- addressB  in  AW  decode read address B.
- hazard_a  out  1  combinational; addressA has a pending or in-flight write.
- hazard_b  out  1  combinational; same for addressB.

Behaviour:
- **State:**
  - Buffers abuf and mbuf, each holding {v, addr, data}.
  - old: 1 bit, marks which buffer was loaded first; valid only when both are full.
  - rr: round-robin pointer naming the last requester granted; 0 = ALU, 1 = MEM.
- **Reset (CLR high, asynchronous):**
  - Both buffers empty; rr = 1, so the ALU is favoured first.
  - RW = 0, pc_wr = 0, writeAddress = 0, I0 = 0.
  - CLR asserted mid-operation drops all buffered writes and any write being set up.
- **Grant (combinational, from buffer state only; never from the *_valid inputs):**
  - Only one buffer full: grant it.
  - Both full, accepted on different cycles: grant the older one (old).
  - Both full, accepted on the same edge, different addresses: grant the side not named by rr.
  - Both full, accepted on the same edge, same address: grant the ALU first, so the load value is the final register content.
  - No buffer full: no grant.
- **Ready:**
  - alu_ready = ~abuf.v | grant_alu; mem_ready likewise.
  - A buffer can therefore drain and refill on the same edge, giving a sustained rate of 1 write per cycle.
  - Both ready outputs are 0 while flush is high.
- **Issue edge (with a grant):**
  - RW <= 1, writeAddress <= granted addr, I0 <= granted data.
  - pc_wr <= (granted addr == PC_ADDR).
  - Granted buffer clears, unless it is refilled on that same edge.
  - rr <= granted side.
- **No grant:** RW <= 0 and pc_wr <= 0; writeAddress and I0 hold their last values.
- **Latency:** a request accepted at edge N drives RW high during cycle N+1 at the earliest. register_file latches it at edge N+2.
- **Flush:** on the edge where flush is high, both buffers clear and no new accept occurs. An RW already registered high still completes.
- **Hazard:** hazard_a = (abuf.v & abuf.addr == addressA) | (mbuf.v & mbuf.addr == addressA) | (RW & writeAddress == addressA). hazard_b is the same using addressB.
- **Address width:** full 4-bit compare; R15 gets no special treatment apart from pc_wr.

Test Plan:
- **Reset:** CLR pulse mid-stream -> RW = 0, I0 = 0, both ready = 1, hazard_a = 0 for addressA = 4'h0.
- **Single ALU write:** alu_valid for 1 cycle, alu_addr = 4'h3, alu_data = 32'h0000_00AA -> RW = 1 for exactly one cycle, one cycle later; R3 reads 32'h0000_00AA afterwards.
- **Simultaneous, different addresses:** ALU R1 = 32'h11, MEM R2 = 32'h22 on the same edge after reset -> R1 issued first (rr = 1), then R2 the next cycle, with no idle cycle between.
- **Simultaneous, same address:** ALU R5 = 32'h55, MEM R5 = 32'h66 on the same edge -> issue order ALU then MEM; R5 = 32'h66 at the end.
- **Back-to-back streaming:** both requesters valid for 16 cycles, writing R0..R15 with data = address -> RW high every cycle and grants alternate. Every register holds its index, and pc_wr pulses only for R15.
- **Hazard and flush:** MEM R7 accepted with addressA = 4'h7 -> hazard_a = 1 until the cycle after RW drops. Repeat with flush on the edge after accept -> RW is never issued for R7, and hazard_a falls to 0.
